kogge_stone_subtractor_controller: RTL and testbench
====================================================

# kogge_stone_subtractor_controller

Clocked front-end for the 8-bit ALU that captures two operands from a shared input bus and computes A − B through a registered datapath. Button presses are synchronised and edge-detected, and the operand sequence is sequenced by a small FSM. The subtraction is done by the existing `kogge_stone_adder` with the B operand inverted and carry-in tied to 1. Results come out with borrow, overflow, zero and valid flags. This is the subtract counterpart of the add-side controller.

## Interface
- `WIDTH`, default 8: operand and result width; must be ≥ 2.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `in`  in  WIDTH: shared operand bus, sampled directly with no synchroniser (switches are quasi-static).
- `store_A`  in  1: level button for loading operand A; asynchronous to `clk`.
- `store_B`  in  1: level button for loading operand B; asynchronous to `clk`.
- `out`  out  WIDTH: registered result, A − B modulo 2^WIDTH.
- `bout`  out  1: registered borrow; 1 when unsigned A < B.
- `ovf`  out  1: registered signed (two's-complement) overflow.
- `zero`  out  1: registered; 1 when the result is 0.
- `valid`  out  1: `out` and the flags reflect the current A and B.

## Operation
- **Button conditioning.**
  - Each button passes through a 2-flop synchroniser, then a third flop.
  - A one-cycle `loadX` pulse is generated as `sync2 & ~sync3`.
  - A held button produces exactly one pulse; a release produces none.
- **Operand registers.**
  - `numA` loads `in` on a `loadA` pulse.
  - `numB` loads `in` on a `loadB` pulse.
- **Datapath.**
  - `kogge_stone_adder(numA, ~numB, 1'b1, diff, c)`.
  - `bout = ~c`.
  - `ovf = (numA[MSB] != numB[MSB]) & (diff[MSB] != numA[MSB])`.
  - `zero = (diff == 0)`.
- **FSM states:** EMPTY, HAVE_A, CALC, DONE.
  - EMPTY:
    - `loadA` → HAVE_A.
    - `loadB` alone is ignored: B is not loaded and the state stays EMPTY.
  - HAVE_A: `loadB` → CALC.
  - CALC: unconditional → DONE. On this edge `out`, `bout`, `ovf` and `zero` capture the datapath and `valid` is set to 1.
  - DONE:
    - `loadB` → CALC (new B, recompute).
    - `loadA` → HAVE_A (new A, `valid` cleared).
  - `loadA` in any state reloads A, goes to HAVE_A and clears `valid`.
- **Simultaneous `loadA` and `loadB` in the same cycle:** in any state, both registers load the same `in` value and the next state is CALC. The resulting output is 0 with `zero` = 1.
- **Result hold.** `out` and the flags hold their last value outside the CALC→DONE edge, even while `valid` = 0.
- **Reset.**
  - `rst` high asynchronously clears: `numA`, `numB`, all synchroniser flops, `out`, `bout`, `ovf`, `zero` and `valid` (all 0). The state goes to EMPTY.
  - Reset mid-sequence abandons the sequence. A button still held at release of reset produces a `loadX` pulse once synchronised; this is required behaviour.

## Timing
- A button first sampled high at edge k gives `sync2` high after k+1. The `loadX` pulse is high during the cycle after edge k+1.
- The operand register loads at edge k+2, capturing `in` as it is at that edge.
- `loadB` at edge k+2 (HAVE_A→CALC) puts `out`, the flags and `valid` = 1 at edge k+3. Button-to-result latency is 3 edges.
- `loadA` from DONE at edge k+2 gives `valid` = 0 after that edge.
- Back-to-back presses: minimum spacing is 1 cycle low between presses as seen by the synchroniser. Each clean low→high transition produces one pulse.
- `in` must be stable for the cycle around edge k+2; no other setup requirement applies.

## Test plan
- **Basic subtract.** Reset; press A with `in` = 0x50; press B with `in` = 0x20. Expect `out` = 0x30, `bout` = 0, `ovf` = 0, `zero` = 0, and `valid` rising exactly 3 edges after B is first sampled.
- **Borrow.** A = 0x20, B = 0x50. Expect `out` = 0xD0, `bout` = 1, `ovf` = 0, `valid` = 1.
- **Signed overflow and zero.**
  - A = 0x80, B = 0x01: expect `out` = 0x7F, `ovf` = 1, `bout` = 0.
  - Then press B with 0x80: expect `out` = 0x00, `zero` = 1, `valid` stays 1 (DONE→CALC→DONE).
- **Held button and ignored B.**
  - From EMPTY, press B with 0x33: expect no state change and `valid` = 0.
  - Hold A for 20 cycles with `in` changing after edge k+2: expect `numA` loaded once, with the k+2 value.
  - Press B with 0x10 and A = 0x33: expect `out` = 0x23.
- **Simultaneous and re-arm.**
  - From DONE, raise A and B in the same cycle with `in` = 0x5A: expect `out` = 0x00, `zero` = 1, `valid` = 1.
  - Then press A alone: expect `valid` = 0 and `out` holding 0x00.
- **Reset mid-operation.** In HAVE_A with A = 0x44, assert `rst` asynchronously between edges. Expect all outputs 0 and state EMPTY immediately. After release, a B press is ignored and `valid` stays 0.

Source files
------------

// File: rtl/kogge_stone_subtractor_controller_if.sv
// ---------------------------------------------------------------------------
// kogge_stone_subtractor_controller_if: operand bus, buttons and result flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface kogge_stone_subtractor_controller_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             store_A;
  logic             store_B;
  logic [WIDTH-1:0] out;
  logic             bout;
  logic             ovf;
  logic             zero;
  logic             valid;

  modport master (
    output in, store_A, store_B,
    input  out, bout, ovf, zero, valid
  );

  modport slave (
    input  in, store_A, store_B,
    output out, bout, ovf, zero, valid
  );
endinterface

`default_nettype wire

// File: rtl/kogge_stone_subtractor_controller.sv
// ---------------------------------------------------------------------------
// kogge_stone_subtractor_controller: button-sequenced registered A - B unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module kogge_stone_adder #(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic             cin,
  output logic      [WIDTH-1:0] sum,
  output logic                  cout
);
  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] g_cur;
  logic [WIDTH-1:0] p_cur;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] p_nxt;

  assign prop = a ^ b;

  // cin is folded into bit 0's generate, so after the last prefix level
  // g_cur[i] is the carry out of bit i
  always_comb begin
    g_cur    = a & b;
    p_cur    = prop;
    g_cur[0] = g_cur[0] | (p_cur[0] & cin);
    g_nxt    = '0;
    p_nxt    = '0;
    for (int l = 0; l < LEVELS; l++) begin
      g_nxt = g_cur;
      p_nxt = p_cur;
      for (int i = (1 << l); i < WIDTH; i++) begin
        g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << l)]);
        p_nxt[i] = p_cur[i] & p_cur[i - (1 << l)];
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
  end

  assign sum  = prop ^ {g_cur[WIDTH-2:0], cin};
  assign cout = g_cur[WIDTH-1];
endmodule

module kogge_stone_subtractor_controller #(
  parameter int WIDTH = 8
) (
  input  wire logic                                clk,
  input  wire logic                                rst,
  kogge_stone_subtractor_controller_if.slave       bus
);
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_a_q, sync_a_d;
  logic [2:0]       sync_b_q, sync_b_d;
  logic [WIDTH-1:0] num_a_q, num_a_d;
  logic [WIDTH-1:0] num_b_q, num_b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic             load_a;
  logic             load_b;
  logic [WIDTH-1:0] diff;
  logic             carry;

  kogge_stone_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (num_a_q),
    .b    (~num_b_q),
    .cin  (1'b1),
    .sum  (diff),
    .cout (carry)
  );

  // bit0/bit1 synchronise, bit2 is the delayed copy used for edge detection
  assign sync_a_d = {sync_a_q[1:0], bus.store_A};
  assign sync_b_d = {sync_b_q[1:0], bus.store_B};
  assign load_a   = sync_a_q[1] & ~sync_a_q[2];
  assign load_b   = sync_b_q[1] & ~sync_b_q[2];

  always_comb begin
    state_d = state_q;
    num_a_d = num_a_q;
    num_b_d = num_b_q;
    out_d   = out_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = valid_q;

    if (state_q == CALC && !load_a) begin
      out_d   = diff;
      bout_d  = ~carry;
      ovf_d   = (num_a_q[WIDTH-1] != num_b_q[WIDTH-1]) &&
                (diff[WIDTH-1] != num_a_q[WIDTH-1]);
      zero_d  = (diff == '0);
      valid_d = 1'b1;
      state_d = DONE;
    end

    // A press always wins the next state; a lone B press is dropped in EMPTY
    if (load_a && load_b) begin
      num_a_d = bus.in;
      num_b_d = bus.in;
      valid_d = 1'b0;
      state_d = CALC;
    end else if (load_a) begin
      num_a_d = bus.in;
      valid_d = 1'b0;
      state_d = HAVE_A;
    end else if (load_b && state_q != EMPTY) begin
      num_b_d = bus.in;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      sync_a_q <= '0;
      sync_b_q <= '0;
      num_a_q  <= '0;
      num_b_q  <= '0;
      out_q    <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      num_a_q  <= num_a_d;
      num_b_q  <= num_b_d;
      out_q    <= out_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.bout  = bout_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;
  assign bus.valid = valid_q;
endmodule

`default_nettype wire

// File: tb/tb_kogge_stone_subtractor_controller.sv
// ---------------------------------------------------------------------------
// tb_kogge_stone_subtractor_controller: scoreboard bench for the A - B unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_kogge_stone_subtractor_controller;
  typedef struct packed {
    logic [7:0] out;
    logic       bout;
    logic       ovf;
    logic       zero;
  } res_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  res_t exp_q[$];

  kogge_stone_subtractor_controller_if #(.WIDTH(8)) bus ();

  kogge_stone_subtractor_controller #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    int   sd;
    r.out  = a - b;
    r.bout = (a < b);
    sd     = int'($signed(a)) - int'($signed(b));
    r.ovf  = (sd > 127) || (sd < -128);
    r.zero = (r.out == 8'h00);
    return r;
  endfunction

  task automatic press(input logic a, input logic b, input logic [7:0] val, input int hold);
    @(negedge clk);
    bus.in      = val;
    bus.store_A = a;
    bus.store_B = b;
    repeat (hold) @(negedge clk);
    bus.store_A = 1'b0;
    bus.store_B = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Button raised just before edge k; result must land exactly at edge k+3
  task automatic press_timed(input logic a, input logic b, input logic [7:0] val,
                             input logic [7:0] a_exp, input logic valid_k2,
                             input string tag);
    res_t e;
    @(negedge clk);
    bus.in      = val;
    bus.store_A = a;
    bus.store_B = b;
    exp_q.push_back(model(a_exp, val));
    repeat (3) @(posedge clk);
    #1 check({tag, "_valid_k2"}, 32'(bus.valid), 32'(valid_k2));
    @(posedge clk);
    #1 check({tag, "_valid_k3"}, 32'(bus.valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_out"},  32'(bus.out),  32'(e.out));
      check({tag, "_bout"}, 32'(bus.bout), 32'(e.bout));
      check({tag, "_ovf"},  32'(bus.ovf),  32'(e.ovf));
      check({tag, "_zero"}, 32'(bus.zero), 32'(e.zero));
    end
    @(negedge clk);
    bus.store_A = 1'b0;
    bus.store_B = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] out_e,
                               input logic bout_e, input logic ovf_e,
                               input logic zero_e, input logic valid_e);
    check({tag, "_out"},   32'(bus.out),   32'(out_e));
    check({tag, "_bout"},  32'(bus.bout),  32'(bout_e));
    check({tag, "_ovf"},   32'(bus.ovf),   32'(ovf_e));
    check({tag, "_zero"},  32'(bus.zero),  32'(zero_e));
    check({tag, "_valid"}, 32'(bus.valid), 32'(valid_e));
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    rst         = 1'b1;
    bus.in      = 8'h00;
    bus.store_A = 1'b0;
    bus.store_B = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic subtract
    press(1'b1, 1'b0, 8'h50, 3);
    press_timed(1'b0, 1'b1, 8'h20, 8'h50, 1'b0, "basic");

    // borrow: a fresh A press must drop valid first
    press(1'b1, 1'b0, 8'h20, 3);
    check("borrow_a_clears_valid", 32'(bus.valid), 32'd0);
    check("borrow_hold_out", 32'(bus.out), 32'h30);
    press_timed(1'b0, 1'b1, 8'h50, 8'h20, 1'b0, "borrow");

    // signed overflow, then recompute from DONE to a zero result
    press(1'b1, 1'b0, 8'h80, 3);
    press_timed(1'b0, 1'b1, 8'h01, 8'h80, 1'b0, "ovf");
    press_timed(1'b0, 1'b1, 8'h80, 8'h80, 1'b1, "zero");

    // ignored B from EMPTY
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    press(1'b0, 1'b1, 8'h33, 3);
    check_outputs("ignored_b", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // held A: only the value present at edge k+2 is captured
    @(negedge clk);
    bus.in      = 8'h33;
    bus.store_A = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.in = 8'($urandom_range(255, 0)) | 8'h80;
    end
    bus.store_A = 1'b0;
    repeat (3) @(negedge clk);
    check("held_valid", 32'(bus.valid), 32'd0);
    press_timed(1'b0, 1'b1, 8'h10, 8'h33, 1'b0, "held");

    // simultaneous A and B from DONE
    press_timed(1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, "simul");

    // re-arm with A alone: valid drops, result holds
    press(1'b1, 1'b0, 8'h11, 3);
    check_outputs("rearm", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // asynchronous reset in HAVE_A
    press(1'b1, 1'b0, 8'h44, 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_outputs("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    press(0, 1'b1, 8'h10, 3);
    repeat (3) @(negedge clk);
    check_outputs("post_rst_b", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule

`default_nettype wire
